// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage with a DEPTH-entry FIFO toward decode.
//
// Drives imem_addr from the pc register and captures the combinationally read
// word imem_rdata. Each fetched word is stored with its PC in a FIFO. The FIFO
// presents its head to decode through a valid/ready handshake.
//
// Control:
//   start  - load start_addr, flush the queue, enter RUN (any state)
//   taken  - in RUN: redirect to target and flush the queue
//   halt   - in RUN: stop fetching. Already queued entries keep draining.
// Priority within a cycle: reset > start > taken > halt > normal fetch.
//
// Ports:
//   f_clk, f_rst_n        clock, synchronous active-low reset
//   start, start_addr     program entry
//   taken, target         branch redirect
//   halt                  stop fetching
//   imem_addr, imem_rdata instruction memory interface (imem_addr == pc)
//   out_valid/out_ready   head handshake toward decode
//   out_instr, out_pc     head contents
//   running               state == RUN
//   q_count               current queue occupancy
//
// Optional feature macro: FETCH_STATS_EN adds saturating 16-bit counters
// fetch_cnt (pushes) and flush_cnt (flushes that discard at least one entry).
module fetch_queue_unit #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     f_clk,
  input  logic                     f_rst_n,
  input  logic                     start,
  input  logic [PC_W-1:0]          start_addr,
  input  logic                     taken,
  input  logic [PC_W-1:0]          target,
  input  logic                     halt,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic                     running,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]              fetch_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [INSTR_W-1:0]  instr_buf_q [DEPTH];
  logic [PC_W-1:0]     pc_buf_q    [DEPTH];

  logic pop, push, flush, full;

  assign pop  = (count_q != '0) && out_ready;
  assign full = (count_q == CntW'(DEPTH));

  // Next state and pc. push also covers the full-and-popping case, because the
  // pop frees the slot in the same edge.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    push    = 1'b0;
    if (start) begin
      state_d = StRun;
      pc_d    = start_addr;
      flush   = 1'b1;
    end else if (state_q == StRun) begin
      if (taken) begin
        pc_d  = target;
        flush = 1'b1;
      end else if (halt) begin
        state_d = StHalted;
      end else if (!full || pop) begin
        push = 1'b1;
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  // Queue pointers and occupancy. A flush discards everything, including an
  // entry that decode accepts in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge f_clk) begin
    if (!f_rst_n) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset. Occupancy alone decides validity.
  always_ff @(posedge f_clk) begin
    if (f_rst_n && push) begin
      instr_buf_q[wr_ptr_q] <= imem_rdata;
      pc_buf_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = instr_buf_q[rd_ptr_q];
  assign out_pc    = pc_buf_q[rd_ptr_q];
  assign running   = (state_q == StRun);
  assign q_count   = count_q;

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;
  logic        discard;

  // An entry accepted by decode during the flush cycle counts as consumed.
  assign discard = flush && ((count_q - CntW'(pop)) != '0);

  always_ff @(posedge f_clk) begin
    if (!f_rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != 16'hFFFF))    fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (discard && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 9;
  localparam int DEPTH   = 4;

  logic               f_clk;
  logic               f_rst_n;
  logic               start;
  logic [PC_W-1:0]    start_addr;
  logic               taken;
  logic [PC_W-1:0]    target;
  logic               halt;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               running;
  logic [$clog2(DEPTH):0] q_count;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  fetch_queue_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .f_clk      (f_clk),
    .f_rst_n    (f_rst_n),
    .start      (start),
    .start_addr (start_addr),
    .taken      (taken),
    .target     (target),
    .halt       (halt),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .running    (running),
    .q_count    (q_count)
`ifdef FETCH_STATS_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  // Instruction memory.
  logic [INSTR_W-1:0] mem [256];
  assign imem_rdata = mem[imem_addr];

  // Reference model: the queue contents are the scoreboard itself.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          sb[$];
  logic [PC_W-1:0] m_pc;
  int              m_state;  // 0 idle, 1 run, 2 halted
  bit              checking;
  int              n_cmp;
  int              n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: mid-cycle, while the inputs are stable.
  always @(negedge f_clk) begin
    if (checking) begin
      chk("q_count", int'(q_count), sb.size());
      chk("out_valid", int'(out_valid), int'(sb.size() != 0));
      chk("imem_addr", int'(imem_addr), int'(m_pc));
      chk("running", int'(running), int'(m_state == 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          entry_t e;
          e = sb.pop_front();
          chk("out_pc", int'(out_pc), int'(e.pc));
          chk("out_instr", int'(out_instr), int'(e.instr));
        end
      end
    end
  end

  // Applies one cycle of inputs and advances the model across the edge. The
  // monitor has already removed this cycle's handshake from sb. Therefore
  // "room for a push" is simply sb.size() < DEPTH.
  task automatic step(input logic rn, input logic st, input logic [PC_W-1:0] sa,
                      input logic tk, input logic [PC_W-1:0] tg, input logic hl,
                      input logic rdy);
    entry_t e;
    f_rst_n = rn; start = st; start_addr = sa; taken = tk; target = tg;
    halt = hl; out_ready = rdy;
    @(posedge f_clk);
    if (!rn) begin
      sb.delete(); m_pc = '0; m_state = 0;
    end else if (st) begin
      sb.delete(); m_pc = sa; m_state = 1;
    end else if (m_state == 1 && tk) begin
      sb.delete(); m_pc = tg;
    end else if (m_state == 1 && hl) begin
      m_state = 2;
    end else if (m_state == 1 && sb.size() < DEPTH) begin
      e.pc = m_pc; e.instr = mem[m_pc];
      sb.push_back(e);
      m_pc = m_pc + 8'd1;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, rdy);
  endtask

  task automatic go(input logic [PC_W-1:0] a, input logic rdy);
    step(1'b1, 1'b1, a, 1'b0, '0, 1'b0, rdy);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; checking = 0;
    m_pc = '0; m_state = 0;
    f_rst_n = 1'b0; start = 1'b0; start_addr = '0; taken = 1'b0; target = '0;
    halt = 1'b0; out_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = INSTR_W'(a);

    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checking = 1;
    idle(2, 1'b1);

    // Straight-line fetch with 1-cycle latency.
    go(8'h10, 1'b1);
    idle(5, 1'b1);

    // Back-pressure fills the queue, then drains in order.
    go(8'h20, 1'b0);
    idle(6, 1'b0);
    idle(10, 1'b1);

    // Taken redirect with 3 queued entries.
    go(8'h70, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 8'h80, 1'b0, 1'b1);
    idle(4, 1'b1);

    // PC wrap.
    go(8'hFE, 1'b1);
    idle(4, 1'b1);

    // Halt with 2 queued entries, ignored taken, then restart.
    go(8'h30, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);
    go(8'h40, 1'b1);
    idle(3, 1'b1);

    // Reset mid-run with a full queue and start asserted.
    go(8'h50, 1'b0);
    idle(5, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b1, 8'h44, 1'b0, 1'b1);
`ifdef FETCH_STATS_EN
    chk("fetch_cnt_reset", int'(fetch_cnt), 0);
    chk("flush_cnt_reset", int'(flush_cnt), 0);
`endif
    idle(2, 1'b1);

    // Randomised traffic with random memory contents.
    for (int a = 0; a < 256; a++) mem[a] = INSTR_W'($urandom);
    go(8'($urandom), 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 24) == 0), 8'($urandom),
           ($urandom_range(0, 11) == 0), 8'($urandom),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) != 0));
    end
    idle(8, 1'b1);

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised successor to the single-register fetch stage. Drives the instruction-memory address and captures the asynchronously read instruction word. Buffers fetched words with their PCs in a DEPTH-entry FIFO toward decode, using a valid/ready handshake. Supports start, taken-branch redirect with queue flush, halt, and back-pressure from decode.

Parameters:
PC_W, 8, program counter / instruction-memory address width
INSTR_W, 9, instruction word width
DEPTH, 4, fetch queue entries (power of two, >=2)

Ports:
f_clk  in  1  clock; all state updates on rising edge
f_rst_n  in  1  synchronous active-low reset
start  in  1  load start_addr, flush queue, enter RUN
start_addr  in  PC_W  program entry address
taken  in  1  branch redirect request (resolved taken branch)
target  in  PC_W  redirect address
halt  in  1  stop fetching (queue keeps draining)
imem_addr  out  PC_W  instruction-memory address (= pc register)
imem_rdata  in  INSTR_W  instruction word at imem_addr, same-cycle combinational read
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  head PC
running  out  1  state == RUN
q_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (f_rst_n=0 at edge): state IDLE, pc=0, queue empty, out_valid=0, q_count=0, running=0. Reset overrides every other input, including mid-run.
- FSM states: IDLE, RUN, HALTED.
  - IDLE -> RUN on start.
  - RUN -> HALTED on halt (with no start and no taken).
  - HALTED -> RUN only on start.
  - taken and halt are ignored in IDLE and HALTED.
- Priority within a cycle: reset > start > taken > halt > normal fetch.
- start (any state):
  - pc<=start_addr; queue flushed (count=0, head invalid next cycle).
  - No enqueue that cycle; pop is discarded.
- taken in RUN:
  - pc<=target; queue flushed; no enqueue that cycle.
  - A simultaneous out_ready handshake still counts as consumed by decode, but the entry is gone after the flush.
- halt in RUN: no enqueue that cycle; pc holds. Entries already queued keep draining via the handshake.
- Normal fetch in RUN:
  - push = (q_count<DEPTH) || pop, where pop = out_valid && out_ready.
  - On push: enqueue {pc, imem_rdata}; pc<=pc+1, wrapping modulo 2^PC_W (all-ones -> 0).
  - No push: pc holds.
- Simultaneous push and pop when full: both occur, q_count unchanged.
- Push and pop when q_count==1: head advances to the new entry, out_valid stays 1.
- Ordering and output timing:
  - Queue is strict FIFO.
  - out_valid = (q_count!=0), registered state, no combinational path from imem_rdata to out_*.
  - A word fetched at edge N is visible on out_* after edge N when the queue was empty (1-cycle latency).
- out_instr/out_pc are don't-care when out_valid=0; the bench must not check them.
- imem_addr = pc at all times, including IDLE/HALTED.

Optional Feature:
FETCH_STATS_EN
- Defined: adds outputs fetch_cnt (16 bits, +1 per push) and flush_cnt (16 bits, +1 per start or taken flush that discards >=1 entry). Both are saturating, reset to 0, and not cleared by start.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, start=1 with start_addr=0x10, out_ready=1, memory word[a]=a -> out_pc 0x10,0x11,0x12 on consecutive cycles after a 1-cycle latency; running=1.
- out_ready=0 from start at 0x20 -> queue fills to q_count=4 (DEPTH=4) holding PCs 0x20..0x23, pc holds at 0x24; release out_ready -> 0x20..0x27 delivered in order with no gaps or duplicates.
- Queue holds 3 entries and taken=1 with target=0x80 -> next cycle q_count=0, out_valid=0; following entries out_pc=0x80,0x81.
- start_addr=0xFE, PC_W=8 -> out_pc sequence 0xFE,0xFF,0x00 (wrap).
- halt with 2 queued entries -> those 2 drain, then out_valid=0, pc constant, running=0; a later taken is ignored; start with 0x40 resumes at 0x40.
- Assert f_rst_n=0 mid-run with a full queue and start=1 -> after the edge q_count=0, pc=0, state IDLE; with FETCH_STATS_EN, both counters read 0.
